// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Top-level game flow controller. It sequences the player ship,
//             the enemy field and the HUD. It owns the level counter, the
//             start/resume/new-game handshakes, the frame-rate movement
//             strobe and the extra-life schedule.
//  Option   : GAME_SEQUENCER_PAUSE_BTN_EN adds a pause_i button that toggles
//             between PLAY and PAUSED.
//  Revision : 1.0  initial release
// ============================================================================
module game_sequencer #(
   parameter int level_width_p   = 4,
   parameter int max_level_p     = 15,
   parameter int move_div_p      = 4,
   parameter int banner_frames_p = 120
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     frame_tick_i,
   input  logic                     shoot_i,
`ifdef GAME_SEQUENCER_PAUSE_BTN_EN
   input  logic                     pause_i,
`endif
   input  logic                     player_alive_i,
   input  logic                     player_hit_i,
   input  logic                     enemies_cleared_i,
   output logic                     new_game_o,
   output logic                     add_life_o,
   output logic                     enemy_reset_o,
   output logic                     move_en_o,
   output logic                     freeze_o,
   output logic                     game_over_o,
   output logic                     banner_o,
   output logic [level_width_p-1:0] level_o,
   output logic [4:0]               state_o
);

   // One-hot state encoding
   localparam logic [4:0] c_ST_IDLE       = 5'b00001;
   localparam logic [4:0] c_ST_PLAY       = 5'b00010;
   localparam logic [4:0] c_ST_PAUSED     = 5'b00100;
   localparam logic [4:0] c_ST_LEVEL_DONE = 5'b01000;
   localparam logic [4:0] c_ST_GAME_OVER  = 5'b10000;

   localparam int c_MOVE_W   = (move_div_p > 1) ? $clog2(move_div_p) : 1;
   localparam int c_BANNER_W = $clog2(banner_frames_p + 1);

   localparam logic [c_MOVE_W-1:0]      c_MOVE_LAST   = c_MOVE_W'(move_div_p - 1);
   localparam logic [c_BANNER_W-1:0]    c_BANNER_LAST = c_BANNER_W'(banner_frames_p - 1);
   localparam logic [level_width_p-1:0] c_LEVEL_MAX   = level_width_p'(max_level_p);
   localparam logic [level_width_p-1:0] c_LEVEL_FIRST = level_width_p'(1);

   logic [4:0]               r_state;
   logic [4:0]               w_state_nxt;
   logic                     r_shoot_q;
   logic [c_MOVE_W-1:0]      r_move_cnt;
   logic [c_BANNER_W-1:0]    r_banner_cnt;
   logic [level_width_p-1:0] r_level;
   logic                     r_new_game;
   logic                     r_add_life;
   logic                     r_enemy_reset;
   logic                     r_move_en;
   logic                     r_freeze;
   logic                     r_game_over;
   logic                     r_banner;

   logic                     w_shoot_pulse;
   logic                     w_resume_pulse;
   logic                     w_pause_pulse;
   logic                     w_banner_done;
   logic                     w_move_wrap;
   logic                     w_start_game;
   logic                     w_enter_ld;
   logic                     w_respawn;

   logic [c_MOVE_W-1:0]      w_move_cnt_nxt;
   logic [c_BANNER_W-1:0]    w_banner_cnt_nxt;
   logic [level_width_p-1:0] w_level_nxt;
   logic                     w_move_en_nxt;

   // Only rising edges of the buttons advance the flow
   assign w_shoot_pulse = shoot_i & ~r_shoot_q;

`ifdef GAME_SEQUENCER_PAUSE_BTN_EN
   logic r_pause_q;

   // Pause button history; held high in reset so a held button is ignored
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_pause_q <= 1'b1;
      else         r_pause_q <= pause_i;
   end

   assign w_pause_pulse  = pause_i & ~r_pause_q;
`else
   assign w_pause_pulse  = 1'b0;
`endif

   assign w_resume_pulse = w_shoot_pulse | w_pause_pulse;

   // Frame ticks are consumed only by the state that is current on that cycle
   assign w_move_wrap   = (r_state == c_ST_PLAY) & frame_tick_i & (r_move_cnt == c_MOVE_LAST);
   assign w_banner_done = (r_state == c_ST_LEVEL_DONE) & frame_tick_i & (r_banner_cnt == c_BANNER_LAST);

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= c_ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic; a hit always outranks a pause or a cleared field
   always_comb begin
      w_state_nxt  = r_state;
      w_start_game = 1'b0;
      w_enter_ld   = 1'b0;
      w_respawn    = 1'b0;
      case (r_state)
         c_ST_IDLE, c_ST_GAME_OVER: begin
            if (w_shoot_pulse) begin
               w_state_nxt  = c_ST_PLAY;
               w_start_game = 1'b1;
            end
         end
         c_ST_PLAY: begin
            if (player_hit_i & ~player_alive_i) begin
               w_state_nxt = c_ST_GAME_OVER;
            end else if (player_hit_i) begin
               w_state_nxt = c_ST_PAUSED;
            end else if (w_pause_pulse) begin
               w_state_nxt = c_ST_PAUSED;
            end else if (enemies_cleared_i) begin
               w_state_nxt = c_ST_LEVEL_DONE;
               w_enter_ld  = 1'b1;
            end
         end
         c_ST_PAUSED: begin
            if (w_resume_pulse) w_state_nxt = c_ST_PLAY;
         end
         c_ST_LEVEL_DONE: begin
            // Timeout and skip together still produce a single respawn
            if (w_shoot_pulse | w_banner_done) begin
               w_state_nxt = c_ST_PLAY;
               w_respawn   = 1'b1;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output and datapath next values, registered below
   always_comb begin
      w_move_cnt_nxt = r_move_cnt;
      if (w_start_game | w_respawn) begin
         w_move_cnt_nxt = '0;
      end else if ((r_state == c_ST_PLAY) & frame_tick_i) begin
         w_move_cnt_nxt = w_move_wrap ? '0 : r_move_cnt + 1'b1;
      end

      w_banner_cnt_nxt = r_banner_cnt;
      if (w_enter_ld) begin
         w_banner_cnt_nxt = '0;
      end else if ((r_state == c_ST_LEVEL_DONE) & frame_tick_i) begin
         w_banner_cnt_nxt = r_banner_cnt + 1'b1;
      end

      w_level_nxt = r_level;
      if (w_start_game) begin
         w_level_nxt = c_LEVEL_FIRST;
      end else if (w_enter_ld && (r_level != c_LEVEL_MAX)) begin
         w_level_nxt = r_level + 1'b1;
      end

      // No movement strobe on the cycle that leaves PLAY
      w_move_en_nxt = w_move_wrap & (w_state_nxt == c_ST_PLAY);
   end

   // Registered outputs, counters and button history
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_shoot_q     <= 1'b1;
         r_move_cnt    <= '0;
         r_banner_cnt  <= '0;
         r_level       <= c_LEVEL_FIRST;
         r_new_game    <= 1'b0;
         r_add_life    <= 1'b0;
         r_enemy_reset <= 1'b0;
         r_move_en     <= 1'b0;
         r_freeze      <= 1'b1;
         r_game_over   <= 1'b0;
         r_banner      <= 1'b0;
      end else begin
         r_shoot_q     <= shoot_i;
         r_move_cnt    <= w_move_cnt_nxt;
         r_banner_cnt  <= w_banner_cnt_nxt;
         r_level       <= w_level_nxt;
         r_new_game    <= w_start_game;
         r_add_life    <= w_enter_ld & ~r_level[0];
         r_enemy_reset <= w_start_game | w_respawn;
         r_move_en     <= w_move_en_nxt;
         r_freeze      <= (w_state_nxt != c_ST_PLAY);
         r_game_over   <= (w_state_nxt == c_ST_GAME_OVER);
         r_banner      <= (w_state_nxt == c_ST_LEVEL_DONE);
      end
   end

   assign new_game_o    = r_new_game;
   assign add_life_o    = r_add_life;
   assign enemy_reset_o = r_enemy_reset;
   assign move_en_o     = r_move_en;
   assign freeze_o      = r_freeze;
   assign game_over_o   = r_game_over;
   assign banner_o      = r_banner;
   assign level_o       = r_level;
   assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_sequencer
//  Purpose  : Self-checking bench for game_sequencer. A driver issues
//             directed and random stimulus and pushes the expected outputs
//             from a behavioural game model into a queue; a monitor pops and
//             compares them each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_sequencer;

   localparam int DIV    = 4;
   localparam int FRAMES = 120;
   localparam int MAXL   = 15;

   typedef logic [15:0] vec_t;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       frame_tick_i = 1'b0;
   logic       shoot_i = 1'b0;
   logic       player_alive_i = 1'b1;
   logic       player_hit_i = 1'b0;
   logic       enemies_cleared_i = 1'b0;
   logic       new_game_o, add_life_o, enemy_reset_o, move_en_o;
   logic       freeze_o, game_over_o, banner_o;
   logic [3:0] level_o;
   logic [4:0] state_o;
   vec_t       obs;

   int checks   = 0;
   int failures = 0;
   int mv_seen  = 0;
   int al_seen  = 0;
   vec_t exp_q[$];
   vec_t mon_e;

   // Behavioural game model: mode 0 idle, 1 play, 2 paused, 3 level done, 4 game over
   int m_mode;
   int m_level;
   int m_moves;
   int m_banner;
   bit m_prev_shoot;

   always #5 clk_i = ~clk_i;

   game_sequencer #(
      .level_width_p  (4),
      .max_level_p    (MAXL),
      .move_div_p     (DIV),
      .banner_frames_p(FRAMES)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .frame_tick_i     (frame_tick_i),
      .shoot_i          (shoot_i),
      .player_alive_i   (player_alive_i),
      .player_hit_i     (player_hit_i),
      .enemies_cleared_i(enemies_cleared_i),
      .new_game_o       (new_game_o),
      .add_life_o       (add_life_o),
      .enemy_reset_o    (enemy_reset_o),
      .move_en_o        (move_en_o),
      .freeze_o         (freeze_o),
      .game_over_o      (game_over_o),
      .banner_o         (banner_o),
      .level_o          (level_o),
      .state_o          (state_o)
   );

   assign obs = {new_game_o, add_life_o, enemy_reset_o, move_en_o,
                 freeze_o, game_over_o, banner_o, level_o, state_o};

   function automatic vec_t model_vec(bit ng, bit al, bit er, bit mv);
      logic [4:0] oh;
      oh = 5'b00001 << m_mode;
      return {ng, al, er, mv, (m_mode != 1), (m_mode == 4), (m_mode == 3), 4'(m_level), oh};
   endfunction

   task automatic model_reset();
      m_mode       = 0;
      m_level      = 1;
      m_moves      = 0;
      m_banner     = 0;
      m_prev_shoot = 1'b1;
   endtask

   task automatic check(input string name, input vec_t got, input vec_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
      end
   endtask

   // One cycle of stimulus; the model's prediction is queued for the monitor
   task automatic step(input bit tick, input bit shoot, input bit alive, input bit hit, input bit cleared);
      bit ng, al, er, mv, press, wrapped;
      @(negedge clk_i);
      reset_i           = 1'b0;
      frame_tick_i      = tick;
      shoot_i           = shoot;
      player_alive_i    = alive;
      player_hit_i      = hit;
      enemies_cleared_i = cleared;
      press        = shoot && !m_prev_shoot;
      m_prev_shoot = shoot;
      ng = 0; al = 0; er = 0; mv = 0; wrapped = 0;
      case (m_mode)
         0, 4: begin
            if (press) begin
               m_mode = 1; m_level = 1; m_moves = 0; ng = 1; er = 1;
            end
         end
         1: begin
            if (tick) begin
               m_moves = m_moves + 1;
               if (m_moves == DIV) begin
                  m_moves = 0;
                  wrapped = 1;
               end
            end
            if (hit && !alive) m_mode = 4;
            else if (hit) m_mode = 2;
            else if (cleared) begin
               al       = (m_level % 2 == 0);
               m_level  = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
               m_banner = 0;
               m_mode   = 3;
            end else begin
               mv = wrapped;
            end
         end
         2: begin
            if (press) m_mode = 1;
         end
         default: begin
            if (tick) m_banner = m_banner + 1;
            if (press || m_banner == FRAMES) begin
               m_mode = 1; m_moves = 0; er = 1;
            end
         end
      endcase
      exp_q.push_back(model_vec(ng, al, er, mv));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
   endtask

   task automatic clear_level(input bit skip);
      step(0, 0, 1, 0, 1);
      if (skip) begin
         step(0, 1, 1, 0, 0);
         step(0, 0, 1, 0, 0);
      end else begin
         for (int i = 0; i < FRAMES; i++) begin
            step(1, 0, 1, 0, 0);
            step(0, 0, 1, 0, 0);
         end
         step(0, 0, 1, 0, 0);
      end
   endtask

   task automatic settle();
      @(posedge clk_i);
      #2;
   endtask

   // Monitor: compares each registered output set against the queued prediction
   always @(posedge clk_i) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (obs !== mon_e) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, obs, mon_e);
         end
         if (move_en_o) mv_seen++;
         if (add_life_o) al_seen++;
      end
   end

   localparam vec_t RST_VEC = {4'b0000, 1'b1, 1'b0, 1'b0, 4'd1, 5'b00001};

   initial begin
      int al_before;
      model_reset();
      shoot_i = 1'b1;                 // held through reset: must not start a game
      #12;
      check("reset_values", obs, RST_VEC);

      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);            // real press
      settle();
      check("start_state", {11'b0, state_o}, {11'b0, 5'b00010});
      check("start_pulses", {13'b0, new_game_o, enemy_reset_o, level_o == 4'd1}, 16'b111);
      step(0, 0, 1, 0, 0);

      mv_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 1, 0, 0);
         step(0, 0, 1, 0, 0);
         step(0, 0, 1, 0, 0);
      end
      settle();
      check("move_pulses_12_ticks", 16'(mv_seen), 16'd3);

      clear_level(0);                 // level 1 -> 2, odd level: no extra life
      al_before = al_seen;
      step(0, 0, 1, 0, 1);            // clear at level 2
      settle();
      check("ld_level2", {banner_o, add_life_o, 10'b0, level_o}, {1'b1, 1'b1, 10'b0, 4'd3});
      for (int i = 0; i < FRAMES; i++) begin
         step(1, 0, 1, 0, 0);
         step(0, 0, 1, 0, 0);
      end
      settle();
      check("banner_timeout_play", {11'b0, state_o}, {11'b0, 5'b00010});
      check("add_life_once", 16'(al_seen - al_before), 16'd1);
      al_before = al_seen;
      clear_level(0);                 // level 3: odd, no extra life
      settle();
      check("no_add_life_l3", 16'(al_seen - al_before), 16'd0);

      step(0, 1, 1, 0, 0);            // shoot edge in PLAY is ignored
      step(0, 1, 1, 1, 1);            // hit and clear together, alive
      settle();
      check("hit_wins_paused", {7'b0, level_o, state_o}, {7'b0, 4'd4, 5'b00100});
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      settle();
      check("held_shoot_stays", {11'b0, state_o}, {11'b0, 5'b00100});
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      settle();
      check("resume_play", {11'b0, state_o}, {11'b0, 5'b00010});
      step(0, 0, 1, 0, 0);

      step(0, 0, 0, 1, 0);            // fatal hit
      settle();
      check("game_over", {14'b0, game_over_o, freeze_o}, 16'b11);
      step(0, 1, 0, 0, 0);
      settle();
      check("restart", {new_game_o, 6'b0, level_o, state_o}, {1'b1, 6'b0, 4'd1, 5'b00010});
      step(0, 0, 1, 0, 0);

      for (int i = 0; i < 16; i++) clear_level(1);
      settle();
      check("level_saturates", {12'b0, level_o}, {12'b0, 4'd15});

      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 29) == 0));
      end

      // Drive back to PLAY, enter LEVEL_DONE, then reset asynchronously
      for (int i = 0; i < 5 && m_mode != 1; i++) begin
         step(0, 0, 1, 0, 0);
         step(0, 1, 1, 0, 0);
      end
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0);
      settle();
      check("in_level_done", {11'b0, state_o}, {11'b0, 5'b01000});
      @(posedge clk_i);
      #3;
      reset_i = 1'b1;
      shoot_i = 1'b0;
      #1;
      check("async_reset", obs, RST_VEC);
      model_reset();
      repeat (2) @(negedge clk_i);
      idle_steps(3);
      step(0, 1, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      idle_steps(4);
      settle();
      #10;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game flow controller that sequences the player ship block, the enemy field and the HUD.
- Owns the level counter, start/resume/new-game handshakes, frame-rate movement enables and the extra-life schedule.
- Consumes the player's alive/hit status and the enemy field's "cleared" flag; drives the player's add-life and new-game inputs and the freeze line shared by all movers.

Parameters:
- level_width_p, 4, width of level_o.
- max_level_p, 15, level_o saturates here; must be < 2**level_width_p.
- move_div_p, 4, frame ticks per move_en_o pulse; must be >= 1.
- banner_frames_p, 120, frame ticks the level-complete banner is held.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- frame_tick_i  in  1  one-cycle pulse per video frame
- shoot_i  in  1  center button, level signal, already debounced
- player_alive_i  in  1  player has lives remaining
- player_hit_i  in  1  player struck this cycle
- enemies_cleared_i  in  1  all enemies destroyed (level signal)
- new_game_o  out  1  one-cycle pulse: reset lives, score and enemy field
- add_life_o  out  1  one-cycle pulse to the player's add-life input
- enemy_reset_o  out  1  one-cycle pulse: respawn the enemy field for the next level
- move_en_o  out  1  one-cycle movement strobe for player, enemies and lasers
- freeze_o  out  1  high whenever state != PLAY
- game_over_o  out  1  high in GAME_OVER
- banner_o  out  1  high in LEVEL_DONE
- level_o  out  level_width_p  current level, 1-based
- state_o  out  5  one-hot present state, for debugging

Behaviour:
- States, one-hot, 5 bits: IDLE=00001, PLAY=00010, PAUSED=00100, LEVEL_DONE=01000, GAME_OVER=10000.
- Illegal encodings, including all-zero, go to IDLE on the next edge.
- Reset values: state IDLE, level_o=1, every pulse output 0, freeze_o=1, banner_o=0, game_over_o=0, internal counters 0, shoot history register 1.
- Resetting the shoot history to 1 means a button held through reset does not start a game.
- shoot_pulse = shoot_i & ~shoot_q, where shoot_q is shoot_i registered. Only rising edges advance the state machine.
- All outputs are registered; each pulse appears on the cycle after its causing input.
- IDLE:
  - shoot_pulse -> PLAY; new_game_o and enemy_reset_o pulse; level_o <= 1.
- PLAY:
  - Move counter increments on frame_tick_i.
  - When the counter reaches move_div_p-1 and frame_tick_i is high, move_en_o pulses and the counter wraps to 0.
- PLAY priority, highest first:
  1. player_hit_i & ~player_alive_i -> GAME_OVER.
  2. player_hit_i & player_alive_i -> PAUSED.
  3. enemies_cleared_i -> LEVEL_DONE.
- Hit and cleared in the same cycle: the hit wins; the level is not credited.
- Entering LEVEL_DONE:
  - If the completed level is even (level_o[0]==0), add_life_o pulses once.
  - level_o <= level_o+1, saturating at max_level_p.
  - The banner counter clears.
- LEVEL_DONE:
  - Banner counter increments on frame_tick_i.
  - Reaching banner_frames_p, or a shoot_pulse (skip), -> PLAY with an enemy_reset_o pulse.
  - If both occur in the same cycle, exactly one pulse is issued.
- PAUSED:
  - Move counter is held (not cleared).
  - shoot_pulse -> PLAY; the move counter resumes from its held value.
- GAME_OVER:
  - shoot_pulse -> PLAY; new_game_o and enemy_reset_o pulse; level_o <= 1.
- move_en_o is never asserted outside PLAY, including the transition cycle out of PLAY.
- frame_tick_i coinciding with a state change is consumed by the old state only.
- Asynchronous reset mid-level or mid-banner returns to the reset values immediately; no pulse is emitted on reset release.

Optional Feature:
- Macro: GAME_SEQUENCER_PAUSE_BTN_EN.
- With the macro: extra input pause_i (1 bit, debounced) is present, with its own edge detector.
  - Rising edge in PLAY -> PAUSED.
  - Rising edge in PAUSED -> PLAY, equivalent to shoot_pulse.
  - In PLAY, a hit in the same cycle takes priority over the pause edge.
- Without the macro: the port is absent; PAUSED is reachable only via a hit.

Test Plan:
- Reset, then a shoot_i rising edge -> next cycle state_o=00010, new_game_o=1 and enemy_reset_o=1 for exactly one cycle, level_o=1.
- PLAY with move_div_p=4 and 12 frame ticks -> exactly 3 move_en_o pulses, one on every 4th tick.
- enemies_cleared_i at level 2 -> add_life_o pulses once, level_o=3, banner_o=1. After 120 frame ticks -> PLAY with one enemy_reset_o pulse. Repeat at level 3 -> no add_life_o.
- player_hit_i=1 and enemies_cleared_i=1 in the same cycle with player_alive_i=1 -> PAUSED, level unchanged. Hold shoot_i high (no new edge) -> stays PAUSED. Release and press again -> PLAY.
- player_hit_i=1 with player_alive_i=0 -> GAME_OVER, game_over_o=1, freeze_o=1. shoot edge -> PLAY, level_o=1, new_game_o pulse. At level 15, clear -> level_o stays 15.
- reset_i asserted mid-LEVEL_DONE, asynchronously to clk_i -> all outputs at their reset values before the next clock edge.
